// File: rtl/all_checker_unit.sv
// Dual-issue hazard checker: decides per cycle which of the two queue-head
// instructions issue (possibly with the younger one swapped ahead), registered.
module all_checker_unit #(
  parameter int des       = 4,
  parameter int source1   = 4,
  parameter int source2   = 4,
  parameter int immediate = 4,
  parameter int branch_id = 3,
  parameter int total_in  = 4 + des + source1 + source2,
  parameter int total_out = total_in + branch_id + 1 + immediate,
  parameter int reg_num   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [total_out-1:0] ins_a,
  input  logic [total_out-1:0] ins_b,
  input  logic [reg_num-1:0]   busy,
  input  logic                 flush,
  output logic                 issue_a,
  output logic                 issue_b,
  output logic                 swap,
  output logic                 raw_hz,
  output logic                 waw_hz,
  output logic                 war_hz,
  output logic                 struct_hz,
  output logic [1:0]           deq_cnt,
  output logic [reg_num-1:0]   set_busy
);

  localparam int OP_LSB  = total_out - 4;
  localparam int DES_LSB = OP_LSB - des;
  localparam int S1_LSB  = DES_LSB - source1;
  localparam int S2_LSB  = S1_LSB - source2;
  localparam int VLD_BIT = immediate;

  typedef struct packed {
    logic               valid;
    logic               rd1;
    logic               rd2;
    logic               wr;
    logic               mem;
    logic               is_br;
    logic               is_halt;
    logic [des-1:0]     dst;
    logic [source1-1:0] s1;
    logic [source2-1:0] s2;
  } dec_t;

  typedef struct packed {
    logic               issue_a;
    logic               issue_b;
    logic               swap;
    logic               raw;
    logic               waw;
    logic               war;
    logic               strct;
    logic [1:0]         deq;
    logic [reg_num-1:0] set_busy;
  } out_t;

  // Register 0 is folded out here: its reads/writes never count as register use.
  function automatic dec_t decode(input logic [total_out-1:0] ins);
    dec_t       d;
    logic [3:0] op;
    op        = ins[OP_LSB +: 4];
    d.valid   = ins[VLD_BIT];
    d.dst     = ins[DES_LSB +: des];
    d.s1      = ins[S1_LSB +: source1];
    d.s2      = ins[S2_LSB +: source2];
    d.mem     = (op == 4'hC) || (op == 4'hD);
    d.is_br   = (op == 4'hE);
    d.is_halt = (op == 4'hF);
    d.rd1     = (op != 4'h0) && (op != 4'hF) && (d.s1 != '0);
    d.rd2     = ((op >= 4'h1 && op <= 4'h7) || op == 4'hD || op == 4'hE) && (d.s2 != '0);
    d.wr      = (op >= 4'h1 && op <= 4'hC) && (d.dst != '0);
    return d;
  endfunction

  function automatic logic ok(input dec_t d, input logic [reg_num-1:0] bsy);
    return d.valid && !(d.rd1 && bsy[d.s1]) && !(d.rd2 && bsy[d.s2])
           && !(d.wr && bsy[d.dst]);
  endfunction

  dec_t da, db;
  logic ok_a, ok_b, both_v;
  logic raw, waw, war, strct;
  out_t state_d, state_q;

  assign da     = decode(ins_a);
  assign db     = decode(ins_b);
  assign ok_a   = ok(da, busy);
  assign ok_b   = ok(db, busy);
  assign both_v = da.valid && db.valid;

  assign raw   = both_v && da.wr && ((db.rd1 && db.s1 == da.dst) || (db.rd2 && db.s2 == da.dst));
  assign waw   = both_v && da.wr && db.wr && (da.dst == db.dst);
  assign war   = both_v && db.wr && ((da.rd1 && da.s1 == db.dst) || (da.rd2 && da.s2 == db.dst));
  assign strct = both_v && da.mem && db.mem;

  // NOTE: every field gets a default before the priority chain so no path leaves a latch.
  always_comb begin
    state_d = '0;
    if (!flush) begin
      state_d.raw   = raw;
      state_d.waw   = waw;
      state_d.war   = war;
      state_d.strct = strct;
      if (da.is_halt) begin
        state_d.issue_a = 1'b1;
      end else if (ok_a) begin
        state_d.issue_a = 1'b1;
        state_d.issue_b = ok_b && !raw && !waw && !strct && !da.is_br && !db.is_halt;
      end else if (ok_b && !raw && !waw && !war && !strct && !da.is_br && !db.is_br
                   && !db.is_halt) begin
        state_d.swap    = 1'b1;
        state_d.issue_b = 1'b1;
      end
    end
    state_d.deq = {1'b0, state_d.issue_a} + {1'b0, state_d.issue_b};
    if (state_d.issue_a && da.wr) state_d.set_busy[da.dst] = 1'b1;
    if (state_d.issue_b && db.wr) state_d.set_busy[db.dst] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignment so all outputs update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign issue_a   = state_q.issue_a;
  assign issue_b   = state_q.issue_b;
  assign swap      = state_q.swap;
  assign raw_hz    = state_q.raw;
  assign waw_hz    = state_q.waw;
  assign war_hz    = state_q.war;
  assign struct_hz = state_q.strct;
  assign deq_cnt   = state_q.deq;
  assign set_busy  = state_q.set_busy;

  // Branch tag and immediate ride along with the instruction but play no part in hazards.
  logic unused_fields;
  assign unused_fields = ^{ins_a[VLD_BIT-1:0], ins_b[VLD_BIT-1:0],
                           ins_a[S2_LSB-1:VLD_BIT+1], ins_b[S2_LSB-1:VLD_BIT+1]};

endmodule

// File: tb/tb_all_checker_unit.sv
// Directed bench for all_checker_unit: hand-computed expectations per step.
module tb_all_checker_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ins_a, ins_b;
  logic [15:0] busy;
  logic        flush;
  logic        issue_a, issue_b, swap, raw_hz, waw_hz, war_hz, struct_hz;
  logic [1:0]  deq_cnt;
  logic [15:0] set_busy;

  int tests = 0;
  int fails = 0;

  all_checker_unit dut (
    .clk(clk), .rst(rst), .ins_a(ins_a), .ins_b(ins_b), .busy(busy), .flush(flush),
    .issue_a(issue_a), .issue_b(issue_b), .swap(swap), .raw_hz(raw_hz),
    .waw_hz(waw_hz), .war_hz(war_hz), .struct_hz(struct_hz),
    .deq_cnt(deq_cnt), .set_busy(set_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 3'b000, 1'b1, 4'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ia, input logic ib, input logic sw,
                           input logic raw, input logic waw, input logic war, input logic st,
                           input logic [1:0] deq, input logic [15:0] sb);
    check({tag, ".issue_a"},   32'(issue_a),   32'(ia));
    check({tag, ".issue_b"},   32'(issue_b),   32'(ib));
    check({tag, ".swap"},      32'(swap),      32'(sw));
    check({tag, ".raw_hz"},    32'(raw_hz),    32'(raw));
    check({tag, ".waw_hz"},    32'(waw_hz),    32'(waw));
    check({tag, ".war_hz"},    32'(war_hz),    32'(war));
    check({tag, ".struct_hz"}, 32'(struct_hz), 32'(st));
    check({tag, ".deq_cnt"},   32'(deq_cnt),   32'(deq));
    check({tag, ".set_busy"},  32'(set_busy),  32'(sb));
  endtask

  task automatic apply(input logic [23:0] a, input logic [23:0] b,
                       input logic [15:0] bsy, input logic fl);
    @(negedge clk);
    ins_a = a; ins_b = b; busy = bsy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ins_a = '0; ins_b = '0; busy = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_init", 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h1, 4'h4, 4'h5, 4'h6), 16'h0000, 1'b0);
    check_all("indep", 1, 1, 0, 0, 0, 0, 0, 2'd2, 16'h0012);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h2, 4'h4, 4'h1, 4'h6), 16'h0000, 1'b0);
    check_all("raw", 1, 0, 0, 1, 0, 0, 0, 2'd1, 16'h0002);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h1, 4'h7, 4'h8, 4'h9), 16'h0004, 1'b0);
    check_all("swap", 0, 1, 1, 0, 0, 0, 0, 2'd1, 16'h0080);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h1, 4'h3, 4'h8, 4'h9), 16'h0004, 1'b0);
    check_all("swap_war", 0, 0, 0, 0, 0, 1, 0, 2'd0, 16'h0000);

    apply(mk(4'hC, 4'h1, 4'h2, 4'h0), mk(4'hC, 4'h4, 4'h5, 4'h0), 16'h0000, 1'b0);
    check_all("struct", 1, 0, 0, 0, 0, 0, 1, 2'd1, 16'h0002);

    apply(mk(4'hE, 4'h0, 4'h2, 4'h3), mk(4'h1, 4'h4, 4'h5, 4'h6), 16'h0000, 1'b0);
    check_all("branch", 1, 0, 0, 0, 0, 0, 0, 2'd1, 16'h0000);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h1, 4'h4, 4'h5, 4'h6), 16'h0000, 1'b1);
    check_all("flush", 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0000);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h1, 4'h3, 4'h5, 4'h6), 16'h0000, 1'b0);
    check_all("war_ok_a", 1, 1, 0, 0, 0, 1, 0, 2'd2, 16'h000A);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h8, 4'h1, 4'h5, 4'h0), 16'h0000, 1'b0);
    check_all("waw", 1, 0, 0, 0, 1, 0, 0, 2'd1, 16'h0002);

    apply(mk(4'h1, 4'h0, 4'h2, 4'h3), mk(4'h1, 4'h4, 4'h0, 4'h6), 16'h0001, 1'b0);
    check_all("reg0", 1, 1, 0, 0, 0, 0, 0, 2'd2, 16'h0010);

    apply(mk(4'hF, 4'h0, 4'h0, 4'h0), mk(4'h1, 4'h4, 4'h5, 4'h6), 16'h0000, 1'b0);
    check_all("halt_a", 1, 0, 0, 0, 0, 0, 0, 2'd1, 16'h0000);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'hF, 4'h0, 4'h0, 4'h0), 16'h0000, 1'b0);
    check_all("halt_b", 1, 0, 0, 0, 0, 0, 0, 2'd1, 16'h0002);

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h1, 4'h4, 4'h5, 4'h6), 16'h0000, 1'b0);
    check_all("pre_rst", 1, 1, 0, 0, 0, 0, 0, 2'd2, 16'h0012);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    apply(mk(4'h1, 4'h1, 4'h2, 4'h3), mk(4'h1, 4'h4, 4'h5, 4'h6), 16'h0000, 1'b0);
    check_all("post_rst", 1, 1, 0, 0, 0, 0, 0, 2'd2, 16'h0012);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
